// File: rtl/ksa_engine_pkg.sv
// ---------------------------------------------------------------------------
// ksa_engine_pkg
//   Shared types and helpers for the RC4 key-scheduling engine.
//   - ksa_state_t     : FSM state encoding used by ksa_engine
//   - KSA_SWAP_CYCLES : clock cycles spent per index in the swap loop
//   - KEY_MAX_BYTES   : widest key the byte selector can address (RC4 max)
//   - key_byte()      : pick byte idx of an n_bytes-long key, byte 0 = MSB
// ---------------------------------------------------------------------------
package ksa_engine_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    READ_I  = 4'd2,
    WAIT_I  = 4'd3,
    READ_J  = 4'd4,
    WAIT_J  = 4'd5,
    WRITE_I = 4'd6,
    WRITE_J = 4'd7,
    DONE    = 4'd8
  } ksa_state_t;

  // READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J
  localparam int unsigned KSA_SWAP_CYCLES = 6;

  // RC4 keys are at most 256 bytes long.
  localparam int unsigned KEY_MAX_BYTES = 256;
  localparam int unsigned KEY_MAX_BITS  = 8 * KEY_MAX_BYTES;

  // key_w holds the key right-aligned; byte 0 sits in the most significant
  // byte of the n_bytes-wide key field.
  function automatic logic [7:0] key_byte(
    input logic [KEY_MAX_BITS-1:0] key_w,
    input int unsigned             n_bytes,
    input int unsigned             idx
  );
    return key_w[8*(n_bytes-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/ksa_engine_key_sel.sv
// ---------------------------------------------------------------------------
// ksa_engine_key_sel
//   Combinational key byte selector: returns key byte number k.
//   Works for any KEY_BYTES (not only powers of two); k must stay below
//   KEY_BYTES, which the engine guarantees by wrapping it explicitly.
// Ports
//   key      in  8*KEY_BYTES  latched key, byte 0 = key[8*KEY_BYTES-1 -: 8]
//   k        in  K_W          byte index
//   key_sel  out 8            selected key byte
// ---------------------------------------------------------------------------
module ksa_engine_key_sel
  import ksa_engine_pkg::*;
#(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned K_W       = 2
) (
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [K_W-1:0]         k,
  output logic [7:0]             key_sel
);

  logic [KEY_MAX_BITS-1:0] key_w;

  assign key_w   = KEY_MAX_BITS'(key);
  assign key_sel = key_byte(key_w, KEY_BYTES, 32'(k));

endmodule

// File: rtl/ksa_engine.sv
// ---------------------------------------------------------------------------
// ksa_engine
//   RC4 key-scheduling engine driving one single-port synchronous RAM
//   (read data valid one clock after the address). Fills S[i]=i, then runs
//   j = j + S[i] + key[i mod KEY_BYTES], swap S[i], S[j] for every i.
//   N = 2**ADDR_W entries. Start/busy/done handshake, abort, init-only mode.
// Ports
//   clk        in   1            system clock
//   reset      in   1            asynchronous, active-low
//   start      in   1            run request, sampled only in IDLE
//   abort      in   1            synchronous cancel, back to IDLE, no done
//   init_only  in   1            1: fill phase only; sampled with start
//   key        in   8*KEY_BYTES  key, latched on start
//   busy       out  1            run in progress
//   done       out  1            one-cycle completion pulse
//   mem_addr   out  ADDR_W       RAM address
//   mem_wdata  out  ADDR_W       RAM write data
//   mem_wren   out  1            RAM write enable
//   mem_rdata  in   ADDR_W       RAM read data
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// INIT    | write S[i] = i, one entry per cycle
// READ_I  | present address i
// WAIT_I  | capture S[i], update j
// READ_J  | present address j
// WAIT_J  | capture S[j]
// WRITE_I | S[i] <= old S[j]
// WRITE_J | S[j] <= old S[i]; advance i and k
// DONE    | done pulse, back to IDLE
// ---------------------------------------------------------------------------
module ksa_engine
  import ksa_engine_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   init_only,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [ADDR_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [ADDR_W-1:0]      mem_rdata
);

  localparam int unsigned K_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [K_W-1:0]    K_LAST = K_W'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST = '1;

  ksa_state_t             state;
  logic [ADDR_W-1:0]      i;
  logic [ADDR_W-1:0]      j;
  logic [K_W-1:0]         k;
  logic [ADDR_W-1:0]      si;
  logic [ADDR_W-1:0]      sj;
  logic [8*KEY_BYTES-1:0] key_q;
  logic                   init_only_q;
  logic [7:0]             key_sel;
  logic [ADDR_W-1:0]      key_adj;

  ksa_engine_key_sel #(
    .KEY_BYTES (KEY_BYTES),
    .K_W       (K_W)
  ) u_key_sel (
    .key     (key_q),
    .k       (k),
    .key_sel (key_sel)
  );

  // Key bytes are 8 bits; fit them to the S-box width (zero-extend or
  // truncate). Truncation is harmless since j is taken modulo N anyway.
  assign key_adj = ADDR_W'(key_sel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      key_q       <= '0;
      init_only_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            key_q       <= key;
            init_only_q <= init_only;
            i           <= '0;
            busy        <= 1'b1;
            state       <= INIT;
          end
        end
        INIT: begin
          if (i == I_LAST) begin
            if (init_only_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              i     <= '0;
              j     <= '0;
              k     <= '0;
              state <= READ_I;
            end
          end else begin
            i <= i + ADDR_W'(1);
          end
        end
        READ_I: state <= WAIT_I;
        WAIT_I: begin
          si    <= mem_rdata;
          j     <= j + mem_rdata + key_adj;
          state <= READ_J;
        end
        READ_J: state <= WAIT_J;
        WAIT_J: begin
          sj    <= mem_rdata;
          state <= WRITE_I;
        end
        WRITE_I: state <= WRITE_J;
        WRITE_J: begin
          k <= (k == K_LAST) ? '0 : k + K_W'(1);
          if (i == I_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i     <= i + ADDR_W'(1);
            state <= READ_I;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // When i == j the WRITE_J store lands on the same word as WRITE_I and
  // restores the original S[i], which is the correct swap result.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      INIT: begin
        mem_addr  = i;
        mem_wdata = i;
        mem_wren  = 1'b1;
      end
      READ_I: mem_addr = i;
      READ_J: mem_addr = j;
      WRITE_I: begin
        mem_addr  = i;
        mem_wdata = sj;
        mem_wren  = 1'b1;
      end
      WRITE_J: begin
        mem_addr  = j;
        mem_wdata = si;
        mem_wren  = 1'b1;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
      end
    endcase
  end

endmodule
